rom_download_ctrl: RTL

//  Upstream stage for the ROM/PROM download path. Takes the MiSTer HPS ioctl stream and produces one

---
 rtl/rom_download_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rom_download_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rom_download_ctrl
// Brief    : HPS ioctl download front end: registered ROM write bus, region
//            select, byte count/checksum, load check and game-core reset hold.
// Revision : 1.0 - initial release
// ============================================================================
module rom_download_ctrl #(
    parameter logic [7:0]  ROM_INDEX   = 8'd0,
    parameter logic [24:0] TOTAL_BYTES = 25'h28600,
    parameter int          RESET_HOLD  = 16
) (
    input  logic        CLK_DL,
    input  logic        RESET_N,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic [24:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        dl_wr,
    output logic [7:0]  dl_sel,
    output logic [24:0] byte_count,
    output logic [7:0]  checksum,
    output logic        overflow,
    output logic        rom_loaded,
    output logic        load_error,
    output logic        core_rst_n
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_CHECK = 3'd2;
    localparam logic [2:0] c_ST_HOLD  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;
    localparam logic [2:0] c_ST_ERROR = 3'd5;

    localparam int                  c_HOLD_W    = $clog2(RESET_HOLD + 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(RESET_HOLD - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_ONE  = c_HOLD_W'(1);

    localparam logic [24:0] c_CNT_MAX = 25'h1FFFFFF;
    localparam logic [24:0] c_EP1_END = 25'h08000;
    localparam logic [24:0] c_EP2_END = 25'h10000;
    localparam logic [24:0] c_EP3_END = 25'h18000;
    localparam logic [24:0] c_EP4_END = 25'h20000;
    localparam logic [24:0] c_EP5_END = 25'h28000;
    localparam logic [24:0] c_CP1_END = 25'h28200;
    localparam logic [24:0] c_CP2_END = 25'h28400;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic                r_match_d;
    logic [c_HOLD_W-1:0] r_hold_cnt;

    logic       w_match;
    logic       w_dl_start;
    logic       w_dl_end;
    logic       w_accept;
    logic       w_in_range;
    logic       w_wr_ok;
    logic       w_ovf_hit;
    logic       w_image_good;
    logic       w_hold_last;
    logic       w_release_nxt;
    logic       w_err_set;
    logic [7:0] w_region_sel;

    // Only downloads aimed at our index exist as far as this block is concerned.
    assign w_match      = ioctl_download & (ioctl_index == ROM_INDEX);
    assign w_dl_start   = w_match & ~r_match_d;
    assign w_dl_end     = ~w_match & r_match_d;
    assign w_accept     = ioctl_wr & w_match;
    assign w_in_range   = (ioctl_addr < TOTAL_BYTES);
    assign w_wr_ok      = w_accept & w_in_range;
    assign w_ovf_hit    = w_accept & ~w_in_range;
    assign w_image_good = (byte_count == TOTAL_BYTES) & ~overflow;
    assign w_hold_last  = (r_hold_cnt == c_HOLD_LAST);

    always_comb begin
        w_region_sel = 8'h01;
        if (ioctl_addr < c_EP1_END) begin
            w_region_sel = 8'h80;
        end else if (ioctl_addr < c_EP2_END) begin
            w_region_sel = 8'h40;
        end else if (ioctl_addr < c_EP3_END) begin
            w_region_sel = 8'h20;
        end else if (ioctl_addr < c_EP4_END) begin
            w_region_sel = 8'h10;
        end else if (ioctl_addr < c_EP5_END) begin
            w_region_sel = 8'h08;
        end else if (ioctl_addr < c_CP1_END) begin
            w_region_sel = 8'h04;
        end else if (ioctl_addr < c_CP2_END) begin
            w_region_sel = 8'h02;
        end
    end

    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= c_ST_IDLE;
            r_match_d <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_match_d <= w_match;
        end
    end

    // A fresh download start overrides whatever the FSM was doing.
    always_comb begin
        w_state_nxt = r_state;
        if (w_dl_start) begin
            w_state_nxt = c_ST_LOAD;
        end else begin
            case (r_state)
                c_ST_LOAD:  if (w_dl_end) w_state_nxt = c_ST_CHECK;
                c_ST_CHECK: w_state_nxt = w_image_good ? c_ST_HOLD : c_ST_ERROR;
                c_ST_HOLD:  if (w_hold_last) w_state_nxt = c_ST_DONE;
                default:    w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_release_nxt = (w_state_nxt == c_ST_DONE);
        w_err_set     = (r_state == c_ST_CHECK) & ~w_image_good & ~w_dl_start;
    end

    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            r_hold_cnt <= '0;
        end else if (r_state == c_ST_HOLD && !w_dl_start) begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_ONE;
        end else begin
            r_hold_cnt <= '0;
        end
    end

    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            rom_loaded <= 1'b0;
            core_rst_n <= 1'b0;
            load_error <= 1'b0;
        end else begin
            rom_loaded <= w_release_nxt;
            core_rst_n <= w_release_nxt;
            if (w_dl_start) begin
                load_error <= 1'b0;
            end else if (w_err_set) begin
                load_error <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            dl_addr <= '0;
            dl_data <= '0;
            dl_wr   <= 1'b0;
            dl_sel  <= '0;
        end else begin
            dl_wr  <= w_wr_ok;
            dl_sel <= w_wr_ok ? w_region_sel : 8'h00;
            if (w_wr_ok) begin
                dl_addr <= ioctl_addr;
                dl_data <= ioctl_dout;
            end
        end
    end

    // Statistics restart on the start edge but still take a byte strobed in that same cycle.
    always_ff @(posedge CLK_DL or negedge RESET_N) begin
        if (!RESET_N) begin
            byte_count <= '0;
            checksum   <= '0;
            overflow   <= 1'b0;
        end else if (w_dl_start) begin
            byte_count <= w_wr_ok ? 25'd1 : 25'd0;
            checksum   <= w_wr_ok ? ioctl_dout : 8'h00;
            overflow   <= w_ovf_hit;
        end else begin
            if (w_wr_ok) begin
                if (byte_count != c_CNT_MAX) begin
                    byte_count <= byte_count + 25'd1;
                end
                checksum <= checksum + ioctl_dout;
            end
            if (w_ovf_hit) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
